// File: rtl/parity_check_rx_serial.sv
// parity_check_rx_serial
//   Bit-serial UART RX parity checker. Parity is accumulated one bit at a time as the
//   RX sampler delivers data bits, so no parallel data word is needed. The frame length,
//   parity mode and parity enable are configured at run time and latched on frame_start.
//   A parity result is reported once per frame.
//
// Optional feature macro: PAR_ERR_CNT_EN
//   When defined, the CNT_W parameter and the err_cnt output exist. err_cnt is a
//   saturating count of par_err pulses. When undefined, both the parameter and the
//   counter logic are removed.
//
// Ports
//   CLK            system clock, rising edge
//   RST            synchronous reset, active-high
//   frame_start    1-cycle pulse after the start bit: latch config, clear accumulator
//   data_len       data bits per frame (0 or > MAX_DATA_LENGTH selects MAX_DATA_LENGTH)
//   par_mode       00 even, 01 odd, 10 mark, 11 space
//   par_en         frame carries a parity bit
//   sample_valid   sample_bit holds the next received bit
//   sample_bit     received bit (data LSB first, then parity)
//   par_clr        clears par_err_sticky (and err_cnt)
//   busy           frame in progress (DATA or PAR)
//   par_done       1-cycle pulse: frame evaluation complete
//   par_err        1-cycle pulse with par_done when parity mismatched
//   par_err_sticky set by par_err, held until par_clr or RST
//   err_cnt        saturating par_err count (PAR_ERR_CNT_EN only)
module parity_check_rx_serial #(
  parameter int unsigned MAX_DATA_LENGTH = 9,
`ifdef PAR_ERR_CNT_EN
  parameter int unsigned CNT_W           = 8,
`endif
  parameter int unsigned LEN_W           = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             frame_start,
  input  logic [LEN_W-1:0] data_len,
  input  logic [1:0]       par_mode,
  input  logic             par_en,
  input  logic             sample_valid,
  input  logic             sample_bit,
  input  logic             par_clr,
  output logic             busy,
  output logic             par_done,
  output logic             par_err,
`ifdef PAR_ERR_CNT_EN
  output logic [CNT_W-1:0] err_cnt,
`endif
  output logic             par_err_sticky
);

  localparam logic [LEN_W-1:0] MaxLen = LEN_W'(MAX_DATA_LENGTH);

  typedef enum logic [1:0] {StIdle, StData, StPar} state_e;

  state_e           state_q, state_d;
  logic             acc_q, acc_d;
  logic [LEN_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [1:0]       mode_q, mode_d;
  logic             en_q, en_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             sticky_q, sticky_d;
  logic [LEN_W-1:0] len_clamped;
  logic             exp_bit;

  // Zero or an oversized request falls back to the largest supported frame.
  always_comb begin
    len_clamped = data_len;
    if ((data_len == '0) || (data_len > MaxLen)) begin
      len_clamped = MaxLen;
    end
  end

  always_comb begin
    exp_bit = acc_q;
    case (mode_q)
      2'b00:   exp_bit = acc_q;
      2'b01:   exp_bit = ~acc_q;
      2'b10:   exp_bit = 1'b1;
      default: exp_bit = 1'b0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    bit_cnt_d = bit_cnt_q;
    len_d     = len_q;
    mode_d    = mode_q;
    en_d      = en_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    // frame_start outranks everything: it aborts any frame and drops a coincident sample.
    if (frame_start) begin
      state_d   = StData;
      acc_d     = 1'b0;
      bit_cnt_d = '0;
      len_d     = len_clamped;
      mode_d    = par_mode;
      en_d      = par_en;
    end else if (sample_valid) begin
      case (state_q)
        StData: begin
          acc_d     = acc_q ^ sample_bit;
          bit_cnt_d = bit_cnt_q + LEN_W'(1);
          if (bit_cnt_d == len_q) begin
            if (en_q) begin
              state_d = StPar;
            end else begin
              state_d = StIdle;
              done_d  = 1'b1;
            end
          end
        end
        StPar: begin
          state_d = StIdle;
          done_d  = 1'b1;
          err_d   = (sample_bit != exp_bit);
        end
        default: ;
      endcase
    end
  end

  // Sticky follows the registered pulse so a par_clr seen with par_err loses to the set.
  always_comb begin
    sticky_d = sticky_q;
    if (err_q) begin
      sticky_d = 1'b1;
    end else if (par_clr) begin
      sticky_d = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= StIdle;
      acc_q     <= 1'b0;
      bit_cnt_q <= '0;
      len_q     <= '0;
      mode_q    <= 2'b00;
      en_q      <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      sticky_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      bit_cnt_q <= bit_cnt_d;
      len_q     <= len_d;
      mode_q    <= mode_d;
      en_q      <= en_d;
      done_q    <= done_d;
      err_q     <= err_d;
      sticky_q  <= sticky_d;
    end
  end

`ifdef PAR_ERR_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // A clear coincident with an error leaves a count of one.
  always_comb begin
    cnt_d = cnt_q;
    if (par_clr) begin
      cnt_d = CNT_W'(err_q);
    end else if (err_q && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign err_cnt = cnt_q;
`endif

  assign busy           = (state_q != StIdle);
  assign par_done       = done_q;
  assign par_err        = err_q;
  assign par_err_sticky = sticky_q;

endmodule

// File: tb/tb_parity_check_rx_serial.sv
module tb_parity_check_rx_serial;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       frame_start = 1'b0;
  logic [3:0] data_len = 4'd0;
  logic [1:0] par_mode = 2'b00;
  logic       par_en = 1'b0;
  logic       sample_valid = 1'b0;
  logic       sample_bit = 1'b0;
  logic       par_clr = 1'b0;
  logic       busy, par_done, par_err, par_err_sticky;
`ifdef PAR_ERR_CNT_EN
  logic [1:0] err_cnt;
`endif

  parity_check_rx_serial #(
    .MAX_DATA_LENGTH(9),
`ifdef PAR_ERR_CNT_EN
    .CNT_W(2),
`endif
    .LEN_W(4)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .frame_start(frame_start),
    .data_len(data_len),
    .par_mode(par_mode),
    .par_en(par_en),
    .sample_valid(sample_valid),
    .sample_bit(sample_bit),
    .par_clr(par_clr),
    .busy(busy),
    .par_done(par_done),
    .par_err(par_err),
`ifdef PAR_ERR_CNT_EN
    .err_cnt(err_cnt),
`endif
    .par_err_sticky(par_err_sticky)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  typedef struct {
    logic err;
    int   cyc;
  } exp_t;
  exp_t sb_q[$];

  // Every par_done must match a queued frame result, arriving on the predicted cycle.
  always @(negedge CLK) begin
    if (!RST && (par_done || par_err)) begin
      if (sb_q.size() == 0) begin
        check("spurious_done", 32'(par_done), 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("par_done", 32'(par_done), 32'd1);
        check("par_err", 32'(par_err), 32'(e.err));
        check("latency", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic model_err(input logic [8:0] data, input int n,
                                     input logic [1:0] mode, input logic pb);
    logic acc;
    logic e;
    acc = 1'b0;
    for (int i = 0; i < n; i++) acc = acc ^ data[i];
    case (mode)
      2'b00:   e = acc;
      2'b01:   e = ~acc;
      2'b10:   e = 1'b1;
      default: e = 1'b0;
    endcase
    return pb != e;
  endfunction

  // Returns in the cycle where the frame result is visible on the outputs.
  task automatic run_frame(input int len_cfg, input logic [1:0] mode, input logic en,
                           input logic [8:0] data, input logic pb);
    int   nbits;
    exp_t e;
    nbits = ((len_cfg == 0) || (len_cfg > 9)) ? 9 : len_cfg;
    frame_start = 1'b1;
    data_len = 4'(len_cfg);
    par_mode = mode;
    par_en = en;
    tick();
    frame_start = 1'b0;
    sample_valid = 1'b0;
    // Config changes after frame_start must not matter.
    data_len = ~data_len;
    par_mode = ~mode;
    par_en = ~en;
    for (int i = 0; i < nbits; i++) begin
      sample_valid = 1'b1;
      sample_bit = data[i];
      if ((i == nbits - 1) && !en) begin
        e.err = 1'b0;
        e.cyc = cyc + 1;
        sb_q.push_back(e);
      end
      tick();
      sample_valid = 1'b0;
      if ((i % 2) == 1 && (i != nbits - 1)) tick();
    end
    if (en) begin
      check("busy_in_par", 32'(busy), 32'd1);
      e.err = model_err(data, nbits, mode, pb);
      e.cyc = cyc + 1;
      sb_q.push_back(e);
      sample_valid = 1'b1;
      sample_bit = pb;
      tick();
      sample_valid = 1'b0;
    end
  endtask

  initial begin
    repeat (3) tick();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(par_done), 32'd0);
    check("rst_err", 32'(par_err), 32'd0);
    check("rst_sticky", 32'(par_err_sticky), 32'd0);
`ifdef PAR_ERR_CNT_EN
    check("rst_cnt", 32'(err_cnt), 32'd0);
`endif
    RST = 1'b0;
    tick();

    // Even, good parity.
    run_frame(8, 2'b00, 1'b1, 9'h0A5, 1'b0);
    tick();
    check("sticky_clean", 32'(par_err_sticky), 32'd0);

    // Odd, bad parity.
    run_frame(8, 2'b01, 1'b1, 9'h0A5, 1'b0);
    tick();
    check("sticky_set", 32'(par_err_sticky), 32'd1);
`ifdef PAR_ERR_CNT_EN
    check("cnt_one", 32'(err_cnt), 32'd1);
`endif

    // Mark then space with a 0 parity bit.
    run_frame(7, 2'b10, 1'b1, 9'h035, 1'b0);
    tick();
    run_frame(7, 2'b11, 1'b1, 9'h035, 1'b0);
    tick();

    // No parity bit.
    run_frame(5, 2'b01, 1'b0, 9'h013, 1'b0);
    check("busy_after_nopar", 32'(busy), 32'd0);
    tick();

    // Abort after 3 bits; the restart coincides with a strobe that must be dropped.
    frame_start = 1'b1;
    data_len = 4'd8;
    par_mode = 2'b00;
    par_en = 1'b1;
    tick();
    frame_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      sample_valid = 1'b1;
      sample_bit = 1'b1;
      tick();
    end
    sample_bit = 1'b1;
    run_frame(8, 2'b00, 1'b1, 9'h0C3, 1'b1);
    tick();

    // Length clamp and short lengths.
    run_frame(0, 2'b00, 1'b1, 9'h1A3, 1'b0);
    tick();
    run_frame(12, 2'b01, 1'b1, 9'h10F, 1'b1);
    tick();
    run_frame(3, 2'b00, 1'b1, 9'h005, 1'b0);
    tick();
    run_frame(3, 2'b01, 1'b1, 9'h005, 1'b0);
    tick();

    // Strobes in IDLE are ignored.
    for (int i = 0; i < 3; i++) begin
      sample_valid = 1'b1;
      sample_bit = i[0];
      tick();
    end
    sample_valid = 1'b0;
    check("idle_busy", 32'(busy), 32'd0);

    par_clr = 1'b1;
    tick();
    par_clr = 1'b0;
    check("clr_sticky", 32'(par_err_sticky), 32'd0);
`ifdef PAR_ERR_CNT_EN
    check("clr_cnt", 32'(err_cnt), 32'd0);
    for (int k = 0; k < 4; k++) begin
      run_frame(8, 2'b01, 1'b1, 9'h0A5, 1'b0);
      tick();
      check("sat_cnt", 32'(err_cnt), (k < 3) ? 32'(k + 1) : 32'd3);
    end
`endif

    // Clear coincident with an error pulse: the set wins.
    run_frame(8, 2'b01, 1'b1, 9'h0A5, 1'b0);
    par_clr = 1'b1;
    tick();
    par_clr = 1'b0;
    check("clr_vs_set_sticky", 32'(par_err_sticky), 32'd1);
`ifdef PAR_ERR_CNT_EN
    check("clr_vs_set_cnt", 32'(err_cnt), 32'd1);
`endif

    // Reset mid-frame discards the partial frame.
    frame_start = 1'b1;
    data_len = 4'd8;
    par_mode = 2'b00;
    par_en = 1'b1;
    tick();
    frame_start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      sample_valid = 1'b1;
      sample_bit = 1'b1;
      tick();
    end
    sample_valid = 1'b0;
    check("busy_mid_frame", 32'(busy), 32'd1);
    RST = 1'b1;
    tick();
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_done", 32'(par_done), 32'd0);
    check("rst_mid_err", 32'(par_err), 32'd0);
    check("rst_mid_sticky", 32'(par_err_sticky), 32'd0);
`ifdef PAR_ERR_CNT_EN
    check("rst_mid_cnt", 32'(err_cnt), 32'd0);
`endif
    RST = 1'b0;
    for (int i = 0; i < 5; i++) begin
      sample_valid = 1'b1;
      sample_bit = 1'b0;
      tick();
    end
    sample_valid = 1'b0;
    check("post_rst_idle", 32'(busy), 32'd0);

    repeat (5) tick();
    check("pending_results", 32'(sb_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
